// File: rtl/ks_voice_alloc.sv
// ks_voice_alloc: assigns note requests to string voices, stealing the oldest
// busy voice when none is free, then fires a one-sample pluck on the next edge.
module ks_voice_alloc #(
    parameter int VOICES = 4,
    parameter int HOLD   = 48000,
    parameter int AGE_W  = 17
) (
    input  logic                  lrck,
    input  logic                  rst,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [9:0]            note_delay,
    input  logic [9:0]            note_volume,
    output logic [10*VOICES-1:0]  voice_delay,
    output logic [10*VOICES-1:0]  voice_volume,
    output logic [VOICES-1:0]     voice_pluck,
    output logic [VOICES-1:0]     voice_busy,
    output logic [2:0]            last_voice,
    output logic                  steal
);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic {IDLE, ARM} state_t;

    state_t state_q, state_d;

    logic [VOICES-1:0]             busy_w;
    logic [VOICES-1:0][AGE_W-1:0]  age_w;
    logic [VOICES-1:0]             pluck_q;
    logic [2:0]                    last_q;
    logic                          steal_q;
    logic                          accept;

    logic [2:0]                    sel_v;
    logic [2:0]                    free_v;
    logic [2:0]                    old_v;
    logic                          any_free;
    logic                          sel_busy;
    logic [AGE_W-1:0]              best_age;

    // State register
    always_ff @(posedge lrck) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; ready is a pure decode of the state
    always_comb begin
        state_d    = state_q;
        note_ready = 1'b0;
        case (state_q)
            IDLE: begin
                note_ready = 1'b1;
                if (note_valid) state_d = ARM;
            end
            ARM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = note_valid & note_ready;

    // Voice choice: lowest free index, else largest age with ties to lowest index
    always_comb begin
        any_free = 1'b0;
        free_v   = 3'd0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!busy_w[i]) begin
                any_free = 1'b1;
                free_v   = 3'(i);
            end
        end
        old_v    = 3'd0;
        best_age = age_w[0];
        for (int i = 1; i < VOICES; i++) begin
            if (age_w[i] > best_age) begin
                best_age = age_w[i];
                old_v    = 3'(i);
            end
        end
        sel_v    = any_free ? free_v : old_v;
        sel_busy = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            if (sel_v == 3'(i)) sel_busy = busy_w[i];
        end
    end

    // Per-voice settings, hold timer and age; allocation overrides expiry
    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        logic [9:0]       dly_q;
        logic [9:0]       vol_q;
        logic [HW-1:0]    hold_q;
        logic [AGE_W-1:0] age_q;
        logic             busy_q;

        always_ff @(posedge lrck) begin
            if (rst) begin
                dly_q  <= '0;
                vol_q  <= '0;
                hold_q <= '0;
                age_q  <= '0;
                busy_q <= 1'b0;
            end else if (accept && sel_v == 3'(g)) begin
                dly_q  <= note_delay;
                vol_q  <= note_volume;
                hold_q <= HW'(HOLD);
                age_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                hold_q <= hold_q - 1'b1;
                if (age_q != '1) age_q <= age_q + 1'b1;
                if (hold_q == HW'(1)) begin
                    busy_q <= 1'b0;
                    age_q  <= '0;
                end
            end
        end

        assign voice_delay[10*g +: 10]  = dly_q;
        assign voice_volume[10*g +: 10] = vol_q;
        assign busy_w[g]                = busy_q;
        assign age_w[g]                 = age_q;
    end

    // Allocation bookkeeping and the one-cycle pluck issued from ARM
    always_ff @(posedge lrck) begin
        if (rst) begin
            pluck_q <= '0;
            last_q  <= '0;
            steal_q <= 1'b0;
        end else begin
            pluck_q <= '0;
            if (accept) begin
                last_q  <= sel_v;
                steal_q <= sel_busy;
            end else if (state_q == ARM) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (last_q == 3'(i)) pluck_q[i] <= 1'b1;
                end
                steal_q <= 1'b0;
            end
        end
    end

    assign voice_pluck = pluck_q;
    assign voice_busy  = busy_w;
    assign last_voice  = last_q;
    assign steal       = steal_q;

endmodule

// File: tb/tb_ks_voice_alloc.sv
// Bench for ks_voice_alloc: directed scenarios plus random traffic, all
// checked every cycle against an array-based model of the allocation rules.
module tb_ks_voice_alloc;
    localparam int V     = 4;
    localparam int HOLD  = 10;
    localparam int AGE_W = 3;
    localparam int AMAX  = 7;

    logic            lrck = 1'b0;
    logic            rst;
    logic            note_valid;
    logic            note_ready;
    logic [9:0]      note_delay;
    logic [9:0]      note_volume;
    logic [10*V-1:0] voice_delay;
    logic [10*V-1:0] voice_volume;
    logic [V-1:0]    voice_pluck;
    logic [V-1:0]    voice_busy;
    logic [2:0]      last_voice;
    logic            steal;

    ks_voice_alloc #(.VOICES(V), .HOLD(HOLD), .AGE_W(AGE_W)) dut (
        .lrck(lrck), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
        .note_delay(note_delay), .note_volume(note_volume),
        .voice_delay(voice_delay), .voice_volume(voice_volume),
        .voice_pluck(voice_pluck), .voice_busy(voice_busy),
        .last_voice(last_voice), .steal(steal)
    );

    always #5 lrck = ~lrck;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int       m_hold[V];
    int       m_age[V];
    int       m_dly[V];
    int       m_vol[V];
    bit       m_busy[V];
    bit       m_ready = 1'b1;
    int       m_last = 0;
    bit       m_steal = 1'b0;
    bit [V-1:0] m_pluck = '0;
    bit       m_acc = 1'b0;

    // Advance the model by one edge using the inputs currently driven
    function automatic void model_step();
        int v;
        bit arm, was_busy;
        m_acc = 1'b0;
        if (rst) begin
            for (int i = 0; i < V; i++) begin
                m_hold[i] = 0; m_age[i] = 0; m_dly[i] = 0; m_vol[i] = 0; m_busy[i] = 0;
            end
            m_ready = 1'b1; m_last = 0; m_steal = 1'b0; m_pluck = '0;
            return;
        end
        arm   = !m_ready;
        m_acc = note_valid && m_ready;
        v = -1;
        for (int i = 0; i < V; i++) if (!m_busy[i] && v < 0) v = i;
        if (v < 0) begin
            v = 0;
            for (int i = 1; i < V; i++) if (m_age[i] > m_age[v]) v = i;
        end
        was_busy = m_busy[v];
        for (int i = 0; i < V; i++) begin
            if (m_acc && i == v) begin
                m_dly[i] = int'(note_delay); m_vol[i] = int'(note_volume);
                m_hold[i] = HOLD; m_age[i] = 0; m_busy[i] = 1'b1;
            end else if (m_busy[i]) begin
                m_hold[i] = m_hold[i] - 1;
                m_age[i]  = (m_age[i] < AMAX) ? m_age[i] + 1 : AMAX;
                if (m_hold[i] == 0) begin m_busy[i] = 1'b0; m_age[i] = 0; end
            end
        end
        m_pluck = '0;
        if (m_acc) begin
            m_last = v; m_steal = was_busy; m_ready = 1'b0;
        end else if (arm) begin
            m_pluck[m_last] = 1'b1; m_steal = 1'b0; m_ready = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [10*V-1:0] ed, ev;
        logic [V-1:0] eb;
        for (int i = 0; i < V; i++) begin
            ed[10*i +: 10] = m_dly[i][9:0];
            ev[10*i +: 10] = m_vol[i][9:0];
            eb[i]          = m_busy[i];
        end
        chk("ready", 64'(note_ready), 64'(m_ready));
        chk("busy", 64'(voice_busy), 64'(eb));
        chk("pluck", 64'(voice_pluck), 64'(m_pluck));
        chk("last", 64'(last_voice), 64'(m_last));
        chk("steal", 64'(steal), 64'(m_steal));
        chk("delay", 64'(voice_delay), 64'(ed));
        chk("volume", 64'(voice_volume), 64'(ev));
    endtask

    task automatic tick();
        model_step();
        @(posedge lrck);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; note_valid = 1'b1; note_delay = 10'd7; note_volume = 10'd9;
        for (int i = 0; i < V; i++) begin
            m_hold[i] = 0; m_age[i] = 0; m_dly[i] = 0; m_vol[i] = 0; m_busy[i] = 0;
        end

        // reset held with a request present: never accepted
        repeat (3) begin
            tick();
            chk("rst_ready", 64'(note_ready), 64'd1);
            chk("rst_busy", 64'(voice_busy), 64'd0);
            chk("rst_delay", 64'(voice_delay), 64'd0);
        end

        // single note from reset
        rst = 1'b0; note_delay = 10'd100; note_volume = 10'd512;
        tick();                                       // E0
        chk("e0_delay0", 64'(voice_delay[9:0]), 64'd100);
        chk("e0_volume0", 64'(voice_volume[9:0]), 64'd512);
        chk("e0_ready", 64'(note_ready), 64'd0);
        note_valid = 1'b0;
        tick();                                       // E1
        chk("e1_pluck", 64'(voice_pluck), 64'b0001);
        chk("e1_ready", 64'(note_ready), 64'd1);
        tick();                                       // E2
        chk("e2_pluck", 64'(voice_pluck), 64'b0000);

        // hold expiry: busy clears exactly HOLD edges after E0
        repeat (7) tick();                            // E9
        chk("hold_e9_busy", 64'(voice_busy[0]), 64'd1);
        tick();                                       // E10
        chk("hold_e10_busy", 64'(voice_busy[0]), 64'd0);
        note_valid = 1'b1; note_delay = 10'd200;
        tick();
        chk("reuse_last", 64'(last_voice), 64'd0);
        chk("reuse_steal", 64'(steal), 64'd0);
        note_valid = 1'b0;
        tick();

        // reset during ARM cancels the pluck
        note_valid = 1'b1; note_delay = 10'd300;
        tick();
        rst = 1'b1; note_valid = 1'b0;
        tick();
        chk("rstarm_pluck", 64'(voice_pluck), 64'd0);
        chk("rstarm_delay", 64'(voice_delay), 64'd0);
        rst = 1'b0;
        tick();
        chk("rstarm_pluck2", 64'(voice_pluck), 64'd0);

        // back-to-back notes with valid held high, then two steals
        note_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            note_delay  = 10'(10 + k);
            note_volume = 10'(20 + k);
            tick();
            chk("b2b_last", 64'(last_voice), 64'((k < 4) ? k : k - 4));
            chk("b2b_steal", 64'(steal), 64'((k >= 4) ? 1 : 0));
            chk("b2b_ready", 64'(note_ready), 64'd0);
            tick();
            chk("b2b_pluck", 64'(voice_pluck), 64'(1 << ((k < 4) ? k : k - 4)));
        end
        note_valid = 1'b0;
        repeat (12) tick();

        // random traffic; an unaccepted request is held until taken
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!(note_valid && !m_acc)) begin
                note_valid  = ($urandom_range(0, 2) != 0);
                note_delay  = 10'($urandom);
                note_volume = 10'($urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ks_voice_alloc.md
# ks_voice_alloc

Voice allocator and pluck sequencer for a bank of `ks_string` instances. It accepts note requests over a valid/ready handshake and assigns each one to a string voice. A free voice is used first; if none is free, the oldest busy voice is stolen. The block then loads that voice's delay and volume settings and fires a one-sample pluck pulse one sample later, so the string sees its new delay before the burst starts. It sits between the note/control front end and the per-string `delay`, `volume` and `pluck` inputs.

## Interface
- `VOICES`, 4: number of strings managed; range 2..8.
- `HOLD`, 48000: samples a voice stays busy after its pluck was scheduled; must be ≥ 1.
- `AGE_W`, 17: width of the per-voice age counter; saturates at all-ones.

- `lrck`  in  1  sample clock; every register updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `note_valid`  in  1  a note request is present.
- `note_ready`  out  1  block can accept a request this cycle.
- `note_delay`  in  10  loop length for the requested note.
- `note_volume`  in  10  output fader setting for the requested note.
- `voice_delay`  out  10*VOICES  per-voice delay, voice i at bits [10i+9:10i].
- `voice_volume`  out  10*VOICES  per-voice volume, same packing.
- `voice_pluck`  out  VOICES  one-cycle pluck pulse per voice.
- `voice_busy`  out  VOICES  voice is holding a note.
- `last_voice`  out  3  index of the most recently allocated voice.
- `steal`  out  1  one-cycle pulse: the last allocation replaced a busy voice.

## Operation
- Reset (`rst`=1 at an edge) sets the following:
  - `voice_delay`, `voice_volume`, `voice_pluck`, `voice_busy`, `last_voice` and `steal` all to 0.
  - All hold and age counters to 0.
  - FSM to IDLE, so `note_ready`=1.
  - Reset mid-sequence (during ARM) cancels the pending pluck.
- FSM states:
  - IDLE: `note_ready`=1.
  - ARM: `note_ready`=0.
  - `note_ready` is decoded from state only; it does not depend on `note_valid`.
- A request is accepted at an edge where `note_valid`=1 and `note_ready`=1.
- Voice selection, combinational in IDLE:
  - Pick the lowest-index voice with `voice_busy`=0.
  - If every voice is busy, pick the voice with the largest age; ties go to the lowest index.
- On accept, for the chosen voice v:
  - `voice_delay[v]` ← `note_delay`; `voice_volume[v]` ← `note_volume`.
  - hold[v] ← HOLD; age[v] ← 0; `voice_busy[v]` ← 1.
  - `last_voice` ← v.
  - `steal` ← 1 if v was busy, otherwise 0.
  - FSM moves to ARM.
- In ARM:
  - Next edge sets `voice_pluck[last_voice]` ← 1 and clears `steal`.
  - FSM returns to IDLE.
- `voice_pluck` is otherwise 0, so every pulse lasts exactly one cycle.
- Every cycle, for each busy voice that is not being allocated in that cycle:
  - hold decrements.
  - age increments, saturating at 2^AGE_W−1.
  - When hold goes from 1 to 0, `voice_busy` clears at that same edge.
- Idle voices keep age = 0 and hold = 0.
- Voices that are not allocated keep their delay and volume values. Only the pluck pulse and the stolen voice's fields change.

## Timing
- Let E0 be the accept edge.
- After E0: new `voice_delay`/`voice_volume` are visible, `note_ready`=0, and `steal` is valid.
- After E1: `voice_pluck[v]`=1, `note_ready`=1, `steal`=0.
- After E2: `voice_pluck[v]`=0. The earliest next accept is E2.
- Throughput is one note per 2 samples.
- Latency from accept to pluck is 1 cycle.
- A note arriving while in ARM stays pending and must be held until `note_ready`.
- Hold expiry at the same edge as an allocation of the same voice: allocation wins (busy stays 1, hold = HOLD).
- `HOLD`=1: the voice is already free at E1, while its pluck still fires after E1.

## Test plan
- Reset → all outputs 0, `note_ready`=1. With `rst` held high for 3 cycles, `note_valid`=1 is never accepted.
- Accept delay=100, volume=512 from reset → after E0 `voice_delay[0]`=100, `voice_volume[0]`=512, `note_ready`=0. After E1 `voice_pluck`=0001. After E2 `voice_pluck`=0000.
- 4 notes back to back, `note_valid` held high → voices allocated 0,1,2,3. Accepts occur only every 2nd edge. `steal` stays 0.
- 5th note with all voices busy → voice 0 (oldest) is reused with `steal`=1. A 6th note then steals voice 1.
- `HOLD`=10, one note, then idle → `voice_busy[0]` clears exactly 10 edges after E0. The next note reuses voice 0 with `steal`=0.
- `rst` asserted in ARM → no `voice_pluck` pulse follows and all fields return to 0.
